// File: rtl/otter_pkg.sv
//==================================================================
// otter_pkg -- shared OTTER opcode, func3 and control-state types (rev 1.0)
//==================================================================
`default_nettype none

package otter_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_PRIV   = 3'b000,
    F3_CSRRW  = 3'b001,
    F3_CSRRS  = 3'b010,
    F3_CSRRC  = 3'b011,
    F3_CSRRWI = 3'b101,
    F3_CSRRSI = 3'b110,
    F3_CSRRCI = 3'b111
  } funct3_system_t;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/otter_cu_fsm.sv
//==================================================================
// otter_cu_fsm -- OTTER multicycle control unit FSM + INSTRET (rev 1.0)
//==================================================================
`default_nettype none

module otter_cu_fsm
  import otter_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  CU_OPCODE,
  input  logic [2:0]  CU_FUNC3,
  input  logic        INTR,
  input  logic        CSR_MIE,
  input  logic        MEM_ACK,
  output logic        PC_RESET,
  output logic        PC_WRITE,
  output logic        REG_WRITE,
  output logic        MEM_RDEN1,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic        CSR_WE,
  output logic        INT_TAKEN,
  output logic        MRET_EXEC,
  output logic [31:0] INSTRET
);

  state_t      state;
  logic [31:0] instret_cnt;
  logic        complete;

  assign INSTRET = instret_cnt;

  // Strobes are a pure decode; reset masks them in the same cycle.
  always_comb begin
    PC_RESET  = 1'b0;
    PC_WRITE  = 1'b0;
    REG_WRITE = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    CSR_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;
    complete  = 1'b0;
    if (!RST) begin
      case (state)
        ST_INIT:  PC_RESET  = 1'b1;
        ST_FETCH: MEM_RDEN1 = 1'b1;
        ST_EXEC: begin
          case (CU_OPCODE)
            OP_LOAD: MEM_RDEN2 = 1'b1;
            OP_STORE: begin
              MEM_WE2  = 1'b1;
              PC_WRITE = MEM_ACK;
              complete = MEM_ACK;
            end
            OP_BRANCH: begin
              PC_WRITE = 1'b1;
              complete = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_REG, OP_IMM: begin
              PC_WRITE  = 1'b1;
              REG_WRITE = 1'b1;
              complete  = 1'b1;
            end
            OP_SYSTEM: begin
              PC_WRITE = 1'b1;
              complete = 1'b1;
              if (CU_FUNC3 == F3_PRIV) begin
                MRET_EXEC = 1'b1;
              end else begin
                CSR_WE    = 1'b1;
                REG_WRITE = 1'b1;
              end
            end
            default: begin
              PC_WRITE = 1'b1;
              complete = 1'b1;
            end
          endcase
        end
        ST_WB: begin
          REG_WRITE = 1'b1;
          PC_WRITE  = 1'b1;
          complete  = 1'b1;
        end
        ST_INTR: begin
          INT_TAKEN = 1'b1;
          PC_WRITE  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_INIT;
      instret_cnt <= 32'd0;
    end else begin
      if (complete) begin
        instret_cnt <= instret_cnt + 32'd1;
      end
      case (state)
        ST_INIT: state <= ST_FETCH;
        ST_FETCH: begin
          if (MEM_ACK) begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC, ST_WB: begin
          // Interrupts are only looked at on the retirement boundary.
          if (complete) begin
            state <= (INTR && CSR_MIE) ? ST_INTR : ST_FETCH;
          end else if (state == ST_EXEC && CU_OPCODE == OP_LOAD && MEM_ACK) begin
            state <= ST_WB;
          end
        end
        ST_INTR: state <= ST_FETCH;
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_otter_cu_fsm.sv
//==================================================================
// tb_otter_cu_fsm -- randomized transaction-level bench for otter_cu_fsm (rev 1.0)
//==================================================================
`default_nettype none

module tb_otter_cu_fsm;

  logic        CLK = 1'b0;
  logic        RST;
  logic [6:0]  CU_OPCODE;
  logic [2:0]  CU_FUNC3;
  logic        INTR;
  logic        CSR_MIE;
  logic        MEM_ACK;
  logic        PC_RESET, PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2;
  logic        MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC;
  logic [31:0] INSTRET;

  otter_cu_fsm dut (
    .CLK(CLK), .RST(RST), .CU_OPCODE(CU_OPCODE), .CU_FUNC3(CU_FUNC3),
    .INTR(INTR), .CSR_MIE(CSR_MIE), .MEM_ACK(MEM_ACK),
    .PC_RESET(PC_RESET), .PC_WRITE(PC_WRITE), .REG_WRITE(REG_WRITE),
    .MEM_RDEN1(MEM_RDEN1), .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2),
    .CSR_WE(CSR_WE), .INT_TAKEN(INT_TAKEN), .MRET_EXEC(MRET_EXEC),
    .INSTRET(INSTRET)
  );

  always #5 CLK = ~CLK;

  localparam logic [8:0] S_PCRST = 9'h100;
  localparam logic [8:0] S_PCW   = 9'h080;
  localparam logic [8:0] S_REGW  = 9'h040;
  localparam logic [8:0] S_RD1   = 9'h020;
  localparam logic [8:0] S_RD2   = 9'h010;
  localparam logic [8:0] S_WE2   = 9'h008;
  localparam logic [8:0] S_CSR   = 9'h004;
  localparam logic [8:0] S_INT   = 9'h002;
  localparam logic [8:0] S_MRET  = 9'h001;

  logic [8:0] strobes;
  assign strobes = {PC_RESET, PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2,
                    MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC};

  int          tests  = 0;
  int          errors = 0;
  logic [31:0] model_ret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs, check strobes mid-cycle, end just after the edge.
  task automatic step(input logic ack, input logic irq, input logic [8:0] exp, input string tag);
    MEM_ACK = ack;
    INTR    = irq;
    @(negedge CLK);
    check(tag, {23'd0, strobes}, {23'd0, exp});
    @(posedge CLK);
    #1;
  endtask

  // Reset while ack is asserted, then expect the INIT cycle.
  task automatic do_reset();
    RST = 1'b1;
    MEM_ACK = 1'b1;
    INTR = rnd();
    @(negedge CLK);
    check("rst_strobes", {23'd0, strobes}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_ret = 32'd0;
    step(rnd(), rnd(), S_PCRST, "init");
    check("instret_rst", INSTRET, model_ret);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, fetch through optional trap.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int fw,
                           input int ew, input logic irq, input logic mie);
    CU_OPCODE = op;
    CU_FUNC3  = f3;
    CSR_MIE   = mie;
    repeat (fw) step(1'b0, rnd(), S_RD1, "fetch_wait");
    step(1'b1, rnd(), S_RD1, "fetch_ack");
    case (op)
      7'b0000011: begin
        repeat (ew) step(1'b0, rnd(), S_RD2, "load_wait");
        step(1'b1, rnd(), S_RD2, "load_ack");
        step(rnd(), irq, S_REGW | S_PCW, "wb");
      end
      7'b0100011: begin
        repeat (ew) step(1'b0, rnd(), S_WE2, "store_wait");
        step(1'b1, irq, S_WE2 | S_PCW, "store_ack");
      end
      7'b1100011: step(rnd(), irq, S_PCW, "branch");
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0110011, 7'b0010011:
        step(rnd(), irq, S_PCW | S_REGW, "alu");
      7'b1110011: begin
        if (f3 == 3'b000) step(rnd(), irq, S_MRET | S_PCW, "mret");
        else              step(rnd(), irq, S_CSR | S_REGW | S_PCW, "csr");
      end
      default: step(rnd(), irq, S_PCW, "nop");
    endcase
    model_ret = model_ret + 32'd1;
    check("instret", INSTRET, model_ret);
    if (irq && mie) begin
      step(rnd(), rnd(), S_INT | S_PCW, "intr");
      check("instret_intr", INSTRET, model_ret);
    end
  endtask

  logic [6:0] ops [12];

  initial begin
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011, 7'b0001111, 7'b1111111};
    RST = 1'b1; CU_OPCODE = 7'd0; CU_FUNC3 = 3'd0;
    INTR = 1'b0; CSR_MIE = 1'b0; MEM_ACK = 1'b0;
    model_ret = 32'd0;
    @(posedge CLK);
    #1;
    do_reset();

    run_instr(7'b0010011, 3'b000, 0, 0, 1'b0, 1'b0);   // ADDI, single-cycle acks
    run_instr(7'b0000011, 3'b010, 0, 3, 1'b0, 1'b0);   // LOAD, ack after 3 waits
    run_instr(7'b0110011, 3'b000, 1, 0, 1'b1, 1'b1);   // ADD with interrupt taken
    run_instr(7'b0110011, 3'b000, 0, 0, 1'b1, 1'b0);   // ADD, interrupt masked
    run_instr(7'b1110011, 3'b000, 0, 0, 1'b0, 1'b0);   // MRET
    run_instr(7'b1110011, 3'b001, 0, 0, 1'b0, 1'b0);   // CSRRW
    run_instr(7'b0100011, 3'b010, 2, 2, 1'b1, 1'b1);   // STORE then interrupt
    run_instr(7'b1100011, 3'b000, 0, 0, 1'b0, 1'b1);   // BRANCH

    for (int n = 0; n < 80; n++) begin
      run_instr(ops[$urandom_range(0, 11)], 3'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rnd(), rnd());
    end

    // Reset while a store is waiting for its ack.
    CU_OPCODE = 7'b0100011;
    CU_FUNC3  = 3'b010;
    CSR_MIE   = 1'b0;
    step(1'b1, 1'b0, S_RD1, "fetch_ack_pre_rst");
    step(1'b0, 1'b0, S_WE2, "store_wait_pre_rst");
    do_reset();

    // Counter wraps from all-ones to zero on the next retirement.
    force dut.instret_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.instret_cnt;
    model_ret = 32'hFFFF_FFFF;
    check("instret_preload", INSTRET, model_ret);
    run_instr(7'b0010011, 3'b000, 0, 0, 1'b0, 1'b0);
    check("instret_wrap", INSTRET, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/otter_cu_fsm.md
OTTER_CU_FSM -- requirements
Module: otter_cu_fsm

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 RST  in  1  synchronous, active-high reset; sampled on CLK rising edge.
REQ-003 CU_OPCODE  in  7  opcode field of the current instruction; valid from EXEC onward.
REQ-004 CU_FUNC3  in  3  func3 field of the current instruction.
REQ-005 INTR  in  1  external interrupt request, level-sensitive.
REQ-006 CSR_MIE  in  1  interrupt-enable bit from the CSR file.
REQ-007 MEM_ACK  in  1  one-cycle completion pulse for the outstanding memory request.
REQ-008 PC_RESET  out  1  forces PC to the reset vector.
REQ-009 PC_WRITE  out  1  PC register load strobe.
REQ-010 REG_WRITE  out  1  register-file write strobe.
REQ-011 MEM_RDEN1  out  1  instruction-fetch read request.
REQ-012 MEM_RDEN2  out  1  data read request.
REQ-013 MEM_WE2  out  1  data write request.
REQ-014 CSR_WE  out  1  CSR write strobe.
REQ-015 INT_TAKEN  out  1  interrupt entry strobe; saves MEPC and selects the trap vector.
REQ-016 MRET_EXEC  out  1  mret strobe; restores interrupt state.
REQ-017 INSTRET  out  32  count of retired instructions.

Function
REQ-018 States SHALL be: INIT, FETCH, EXEC, WB, INTR.
REQ-019 Strobe outputs SHALL decode combinationally from state, opcode, func3 and MEM_ACK; every strobe not named for the current state SHALL be 0.
REQ-020 INIT: PC_RESET=1; next state FETCH unconditionally.
REQ-021 FETCH: MEM_RDEN1=1 every cycle until MEM_ACK=1; on MEM_ACK, next state EXEC; otherwise remain in FETCH.
REQ-022 EXEC with LOAD (0000011): MEM_RDEN2=1 until MEM_ACK; on MEM_ACK, next state WB.
REQ-023 EXEC with STORE (0100011): MEM_WE2=1 until MEM_ACK; PC_WRITE=1 in the MEM_ACK cycle only; this completes the instruction.
REQ-024 EXEC with BRANCH (1100011): PC_WRITE=1 and REG_WRITE=0; this completes the instruction.
REQ-025 EXEC with LUI, AUIPC, JAL, JALR, OP or OP_IMM: PC_WRITE=1 and REG_WRITE=1; this completes the instruction.
REQ-026 EXEC with SYSTEM (1110011) and func3 != 000: CSR_WE=1, REG_WRITE=1, PC_WRITE=1.
REQ-027 EXEC with SYSTEM and func3 == 000: MRET_EXEC=1, PC_WRITE=1, REG_WRITE=0.
REQ-028 EXEC with an unlisted opcode: treated as NOP; PC_WRITE=1 only.
REQ-029 WB: REG_WRITE=1, PC_WRITE=1; this completes the instruction.
REQ-030 At every completion cycle, next state SHALL be INTR if (INTR & CSR_MIE), else FETCH. INTR SHALL NOT be sampled in any other cycle.
REQ-031 INTR: INT_TAKEN=1, PC_WRITE=1; next state FETCH. No retirement occurs in this state.
REQ-032 INSTRET SHALL increment by 1 in each completion cycle and wrap from 0xFFFFFFFF to 0.
REQ-033 MEM_ACK SHALL be ignored in INIT, WB and INTR, and in EXEC for non-memory opcodes.
REQ-034 Latencies with MEM_ACK in the first request cycle: ALU instruction = 2 cycles; LOAD = 3 cycles.
REQ-035 An interrupt arriving mid-instruction SHALL be deferred until that instruction completes.

Reset
REQ-036 RST=1 SHALL force every strobe output to 0 in that cycle, including a pending PC_WRITE or MEM_WE2.
REQ-037 On the clock edge with RST=1, the state SHALL become INIT and INSTRET SHALL become 0, from any state.
REQ-038 The first cycle after reset SHALL show PC_RESET=1 with all other strobes 0.

Structure
REQ-039 opcode_t, funct3_system_t and the state enum SHALL reside in shared package otter_pkg, reused by the decoder.
REQ-040 Single flat module; the FSM and INSTRET counter are inline, no sub-module.

Verification
REQ-041 Reset, then run ADDI (0010011) with MEM_ACK in every request cycle:
 - expect PC_RESET in cycle 1, MEM_RDEN1 in cycle 2, PC_WRITE+REG_WRITE in cycle 3;
 - INSTRET=1 afterward.
REQ-042 LOAD with MEM_ACK delayed 3 cycles in EXEC:
 - MEM_RDEN2 high 4 cycles;
 - then WB asserts REG_WRITE+PC_WRITE for exactly 1 cycle.
REQ-043 Interrupt gating on ADD:
 - INTR=1, CSR_MIE=1 held during ADD: INT_TAKEN+PC_WRITE in the cycle after completion, then FETCH; INSTRET +1 only;
 - repeat with CSR_MIE=0: no INT_TAKEN.
REQ-044 SYSTEM instructions:
 - func3=000: MRET_EXEC=1, REG_WRITE=0;
 - func3=001: CSR_WE=1, REG_WRITE=1.
REQ-045 STORE waiting for MEM_ACK, RST=1 asserted:
 - MEM_WE2=0 in the RST cycle;
 - next cycle PC_RESET=1;
 - INSTRET=0.
REQ-046 Preload INSTRET via 0xFFFFFFFF retirements (force), then retire one more: INSTRET=0.
